// File: rtl/pipe_collect_if.sv
// Stream interface of the frame collector: the PIPE result input, the
// frame-record output handshake, and the sticky drop flag.
interface pipe_collect_if #(
  parameter int DATA_W    = 27,
  parameter int FRAME_LEN = 4
);
  localparam int SUM_W = DATA_W + $clog2(FRAME_LEN);

  logic              in_valid;
  logic [DATA_W-1:0] in_value;
  logic              out_ready;
  logic              out_valid;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic              drop;

  // Producer/consumer side: drives samples and ready, observes records.
  modport master (
    output in_valid, in_value, out_ready,
    input  out_valid, out_sum, out_max, drop
  );

  // Collector side.
  modport slave (
    input  in_valid, in_value, out_ready,
    output out_valid, out_sum, out_max, drop
  );
endinterface

// File: rtl/pipe_collect.sv
// Frame collector: groups FRAME_LEN PIPE results into a {sum, max} record,
// buffers records in a show-ahead FIFO, and flags frames lost to a full FIFO.
// rst_n is an active-high asynchronous reset despite its name.
module pipe_collect #(
  parameter int DATA_W     = 27,
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_collect_if.slave bus
);
  localparam int SUM_W = DATA_W + $clog2(FRAME_LEN);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic {
    EMPTY,
    FILL
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SUM_W-1:0]  acc_sum, acc_sum_nxt;
  logic [DATA_W-1:0] acc_max, acc_max_nxt;

  logic              frame_done;
  logic [SUM_W-1:0]  frame_sum;
  logic [DATA_W-1:0] frame_max;

  logic [SUM_W-1:0]  mem_sum [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_max [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              push_lost;
  logic              drop_q;

  // Frame state and accumulator registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= EMPTY;
      cnt     <= '0;
      acc_sum <= '0;
      acc_max <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc_sum <= acc_sum_nxt;
      acc_max <= acc_max_nxt;
    end
  end

  // Next-state and accumulate logic; the running max is seeded by the first sample of each frame.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_sum_nxt = acc_sum;
    acc_max_nxt = acc_max;
    frame_done  = 1'b0;
    frame_sum   = acc_sum + SUM_W'(bus.in_value);
    frame_max   = ((state == EMPTY) || (bus.in_value > acc_max)) ? bus.in_value : acc_max;
    if (bus.in_valid) begin
      if (cnt == LAST_CNT) begin
        frame_done  = 1'b1;
        state_nxt   = EMPTY;
        cnt_nxt     = '0;
        acc_sum_nxt = '0;
        acc_max_nxt = '0;
      end else begin
        state_nxt   = FILL;
        cnt_nxt     = CNT_W'(cnt + 1'b1);
        acc_sum_nxt = frame_sum;
        acc_max_nxt = frame_max;
      end
    end
  end

  // FIFO push/pop decisions; a push into a full FIFO survives only if the head leaves this cycle.
  always_comb begin
    full      = (occ == FULL_OCC);
    pop       = bus.out_valid && bus.out_ready;
    push_ok   = frame_done && (!full || pop);
    push_lost = frame_done && full && !pop;
  end

  // Record storage; contents are only observed through the valid-gated head outputs.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_sum[wr_ptr] <= frame_sum;
      mem_max[wr_ptr] <= frame_max;
    end
  end

  // Pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)     rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push_ok, pop})
        2'b10:   occ <= OCC_W'(occ + 1'b1);
        2'b01:   occ <= OCC_W'(occ - 1'b1);
        default: occ <= occ;
      endcase
      if (push_lost) drop_q <= 1'b1;
    end
  end

  // Show-ahead head record, forced to zero while the FIFO is empty.
  always_comb begin
    bus.out_valid = (occ != '0);
    bus.out_sum   = bus.out_valid ? mem_sum[rd_ptr] : '0;
    bus.out_max   = bus.out_valid ? mem_max[rd_ptr] : '0;
    bus.drop      = drop_q;
  end
endmodule

// File: tb/tb_pipe_collect.sv
// Self-checking bench for pipe_collect: directed scenarios plus random
// traffic, compared every cycle against a queue-based frame/FIFO model.
module tb_pipe_collect;
  localparam int DATA_W     = 27;
  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    longint sum;
    longint mx;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  rec_t   mq[$];
  longint frame[$];
  bit     m_drop;

  always #5 clk = ~clk;

  pipe_collect_if #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) bus ();

  pipe_collect #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("out_sum", 64'(bus.out_sum), mq[0].sum);
      check("out_max", 64'(bus.out_max), mq[0].mx);
    end
    check("drop", 64'(bus.drop), 64'(m_drop));
  endtask

  task automatic model_clear();
    mq.delete();
    frame.delete();
    m_drop = 1'b0;
  endtask

  // One clock cycle: check registered outputs, present inputs, advance the model to the next edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] val, input bit rdy);
    rec_t   r;
    longint s;
    longint m;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_value  = val;
    bus.out_ready = rdy;
    check_outputs();
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (v) begin
      frame.push_back(longint'(val));
      if (frame.size() == FRAME_LEN) begin
        s = 0;
        m = 0;
        foreach (frame[i]) begin
          s += frame[i];
          if (frame[i] > m) m = frame[i];
        end
        r.sum = s;
        r.mx  = m;
        if (mq.size() < FIFO_DEPTH) mq.push_back(r);
        else m_drop = 1'b1;
        frame.delete();
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next clock.
  task automatic reset_mid();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum",   64'(bus.out_sum),   64'd0);
    check("rst_out_max",   64'(bus.out_max),   64'd0);
    check("rst_drop",      64'(bus.drop),      64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("init_out_valid", 64'(bus.out_valid), 64'd0);
    check("init_out_sum",   64'(bus.out_sum),   64'd0);
    check("init_out_max",   64'(bus.out_max),   64'd0);
    check("init_drop",      64'(bus.drop),      64'd0);
    rst_n = 1'b0;

    // Basic frame 1,2,3,4.
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b1);
    check("basic_valid_next", 64'(bus.out_valid), 64'd0);
    step(1'b0, '0, 1'b1);
    check("basic_sum", 64'(bus.out_sum), 64'd10);
    check("basic_max", 64'(bus.out_max), 64'd4);
    idle(3, 1'b1);

    // Gapped frame with the largest representable sample.
    step(1'b1, DATA_W'(7), 1'b1);
    idle(2, 1'b1);
    step(1'b1, 27'h7FFFFFF, 1'b1);
    idle(1, 1'b1);
    step(1'b1, DATA_W'(0), 1'b1);
    idle(3, 1'b1);
    step(1'b1, DATA_W'(5), 1'b1);
    step(1'b0, '0, 1'b0);
    check("gap_sum", 64'(bus.out_sum), 64'h800000B);
    check("gap_max", 64'(bus.out_max), 64'h7FFFFFF);
    idle(3, 1'b1);

    // Backpressure: five frames into a four-deep FIFO, fifth is lost.
    for (int k = 1; k <= 5; k++)
      for (int j = 0; j < FRAME_LEN; j++) step(1'b1, DATA_W'(k), 1'b0);
    idle(2, 1'b0);
    check("full_drop", 64'(bus.drop), 64'd1);
    idle(7, 1'b1);

    // Reset with buffered records and a partial frame in flight.
    for (int j = 0; j < FRAME_LEN; j++) step(1'b1, DATA_W'(9), 1'b0);
    step(1'b1, DATA_W'(100), 1'b0);
    step(1'b1, DATA_W'(200), 1'b0);
    reset_mid();
    for (int j = 0; j < FRAME_LEN; j++) step(1'b1, DATA_W'(j + 20), 1'b1);
    idle(3, 1'b1);

    // Full FIFO, frame completes on the same cycle as a pop.
    for (int k = 10; k <= 13; k++)
      for (int j = 0; j < FRAME_LEN; j++) step(1'b1, DATA_W'(k), 1'b0);
    for (int j = 0; j < FRAME_LEN - 1; j++) step(1'b1, DATA_W'(14), 1'b0);
    step(1'b1, DATA_W'(14), 1'b1);
    idle(2, 1'b0);
    check("fullpop_no_drop", 64'(bus.drop), 64'd0);
    idle(7, 1'b1);

    // Back-to-back random frames at full rate.
    for (int i = 0; i < 32; i++) step(1'b1, DATA_W'($urandom()), 1'b1);
    idle(4, 1'b1);

    // Random mix of gaps, backpressure and drops.
    for (int i = 0; i < 400; i++)
      step(($urandom() % 4) != 0,
           (($urandom() % 8) == 0) ? 27'h7FFFFFF : DATA_W'($urandom()),
           ($urandom() % 3) == 0);
    idle(8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
